// File: rtl/sram_pkg.sv
// Shared types, widths and helpers for the on-chip SRAM responder.
package sram_pkg;

    localparam int unsigned ADDR_W           = 20;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned CNT_W            = 3;
    localparam int unsigned READ_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        WR_HOLD  = 2'd3
    } sram_state_t;

    // Active-low lane enables to a 16-bit keep mask (disabled lanes read as zero)
    function automatic logic [DATA_W-1:0] lane_mask(input logic ub_n, input logic lb_n);
        return {{8{~ub_n}}, {8{~lb_n}}};
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-addressed RAM: one byte-enabled synchronous write port, one async read port.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH_W = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [1:0]         be,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem_q [0:(1 << DEPTH_W)-1];

    // Byte-lane write; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[1]) mem_q[waddr][15:8] <= wdata[15:8];
            if (be[0]) mem_q[waddr][7:0]  <= wdata[7:0];
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sram_responder.sv
// Emulates the 1Mx16 async SRAM strobes with programmable read latency and a preload port.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH_W  = 10,
    parameter int unsigned READ_LAT = READ_LAT_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               CE,
    input  logic               OE,
    input  logic               WE,
    input  logic               UB,
    input  logic               LB,
    input  logic [19:0]        ADDR,
    input  logic [15:0]        Data_in,
    output logic [15:0]        Data_out,
    output logic               Data_oe,
    input  logic               init_we,
    input  logic [DEPTH_W-1:0] init_addr,
    input  logic [15:0]        init_data,
    output logic               conflict,
    output logic               oob
);

    sram_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DEPTH_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               wr_ub_q, wr_ub_d;
    logic               wr_lb_q, wr_lb_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               data_oe_q, data_oe_d;
    logic               conflict_q, conflict_d;
    logic               oob_q, oob_d;

    logic               addr_same_c;
    logic               hi_nz_c;
    logic               commit_c;
    logic               ram_we_c;
    logic [1:0]         ram_be_c;
    logic [DEPTH_W-1:0] ram_waddr_c;
    logic [DATA_W-1:0]  ram_wdata_c;
    logic [DATA_W-1:0]  ram_rdata_c;
    logic [DATA_W-1:0]  bypass_c;

    assign addr_same_c = (ADDR == rd_addr_q);
    assign hi_nz_c     = |ADDR[ADDR_W-1:DEPTH_W];
    assign commit_c    = (state_q == WR_HOLD) && (WE || CE);

    sram_array #(.DEPTH_W(DEPTH_W)) u_array (
        .clk   (Clk),
        .we    (ram_we_c),
        .be    (ram_be_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .raddr (rd_addr_q[DEPTH_W-1:0]),
        .rdata (ram_rdata_c)
    );

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_ub_q    <= 1'b1;
            wr_lb_q    <= 1'b1;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            conflict_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_ub_q    <= wr_ub_d;
            wr_lb_q    <= wr_lb_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            conflict_q <= conflict_d;
            oob_q      <= oob_d;
        end
    end

    // Next state, latency count, read address latch and write capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ub_d   = wr_ub_q;
        wr_lb_d   = wr_lb_q;

        // Write strobe under CE either opens or extends a write; keep the latest bus values
        if (!CE && !WE) begin
            wr_addr_d = ADDR[DEPTH_W-1:0];
            wr_data_d = Data_in;
            wr_ub_d   = UB;
            wr_lb_d   = LB;
        end

        unique case (state_q)
            IDLE: begin
                if (!CE && !WE) begin
                    state_d = WR_HOLD;
                end else if (!CE && !OE) begin
                    state_d   = RD_WAIT;
                    cnt_d     = CNT_W'(1);
                    rd_addr_d = ADDR;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (CE) begin
                    state_d = IDLE;
                end else if (!WE) begin
                    state_d = WR_HOLD;
                end else if (OE) begin
                    state_d = IDLE;
                end else if (!addr_same_c) begin
                    state_d   = RD_WAIT;
                    cnt_d     = CNT_W'(1);
                    rd_addr_d = ADDR;
                end else if (state_q == RD_WAIT) begin
                    if (cnt_q == CNT_W'(READ_LAT)) state_d = RD_DRIVE;
                    else                           cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            WR_HOLD: begin
                if (WE || CE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM write-port arbitration, read bypass, registered outputs and sticky flags
    always_comb begin
        ram_we_c    = 1'b0;
        ram_be_c    = 2'b00;
        ram_waddr_c = init_addr;
        ram_wdata_c = init_data;
        if (Reset && commit_c) begin
            ram_we_c    = 1'b1;
            ram_be_c    = {~wr_ub_q, ~wr_lb_q};
            ram_waddr_c = wr_addr_q;
            ram_wdata_c = wr_data_q;
        end else if (init_we) begin
            ram_we_c = 1'b1;
            ram_be_c = 2'b11;
        end

        bypass_c = ram_rdata_c;
        if (ram_we_c && (ram_waddr_c == rd_addr_q[DEPTH_W-1:0])) begin
            if (ram_be_c[1]) bypass_c[15:8] = ram_wdata_c[15:8];
            if (ram_be_c[0]) bypass_c[7:0]  = ram_wdata_c[7:0];
        end

        data_oe_d  = (state_d == RD_DRIVE);
        data_out_d = data_oe_d ? (bypass_c & lane_mask(UB, LB)) : '0;
        conflict_d = conflict_q | (!CE && !OE && !WE);
        oob_d      = oob_q | (!CE && (!OE || !WE) && hi_nz_c);
    end

    assign Data_out = data_out_q;
    assign Data_oe  = data_oe_q;
    assign conflict = conflict_q;
    assign oob      = oob_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable on-chip SRAM responder that emulates the 1Mx16 external SRAM seen by the SLC-3 memory subsystem.
- Answers the active-low CE/OE/WE/UB/LB strobes, ADDR and the data bus with a programmable read latency, byte-lane writes and a preload port for loading test programs.
- Sits on the SRAM side of the tristate interface.
- Used in simulation benches and FPGA builds without external SRAM.

Parameters:
- DEPTH_W, 10, log2 of word depth; only ADDR[DEPTH_W-1:0] decodes.
- READ_LAT, 2, cycles from read strobe/address stable to Data_oe assertion; legal range 1..7.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- CE  in  1  chip enable, active low.
- OE  in  1  output enable, active low.
- WE  in  1  write enable, active low.
- UB  in  1  upper byte lane enable, active low.
- LB  in  1  lower byte lane enable, active low.
- ADDR  in  20  word address.
- Data_in  in  16  write data (SRAM side of tristate).
- Data_out  out  16  read data.
- Data_oe  out  1  high when Data_out must drive the bus.
- init_we  in  1  preload write strobe.
- init_addr  in  DEPTH_W  preload address.
- init_data  in  16  preload data.
- conflict  out  1  sticky; set on OE=0 and WE=0 both active under CE=0.
- oob  out  1  sticky; set on any access with ADDR[19:DEPTH_W] nonzero.

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - state=IDLE, Data_out=0, Data_oe=0, conflict=0, oob=0, latency counter=0.
  - Memory contents are NOT cleared.
  - Reset mid-read drops Data_oe the next cycle.
  - Reset mid-write discards the pending write.
- States: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD.
- IDLE:
  - CE=0, WE=0 -> WR_HOLD.
  - CE=0, OE=0, WE=1 -> RD_WAIT with cnt=1 and latched address.
  - Otherwise stay in IDLE.
- RD_WAIT:
  - Each cycle with strobes held and ADDR unchanged, cnt increments.
  - When cnt==READ_LAT -> RD_DRIVE.
  - ADDR change -> cnt=1, new address latched.
  - CE=1 or OE=1 -> IDLE.
  - WE=0 -> WR_HOLD.
- RD_DRIVE:
  - Data_oe=1 (registered).
  - Data_out = mem[addr] with disabled lanes forced to 8'h00 (UB=1 zeroes [15:8], LB=1 zeroes [7:0]).
  - Data_out tracks a same-cycle write via bypass.
  - ADDR change -> RD_WAIT, cnt=1, Data_oe=0.
  - CE=1 or OE=1 -> IDLE, Data_oe=0 next cycle.
- WR_HOLD:
  - Each cycle, Data_in, UB, LB and ADDR are registered.
  - Commit happens on the first cycle WE=1 or CE=1, using the last registered values: mem[addr] lanes with UB=0/LB=0 updated. Then -> IDLE.
  - UB=LB=1 throughout -> no change.
  - Data_oe=0 throughout.
  - OE=0 concurrently with WE=0 -> write wins, conflict<=1.
- Read latency: data visible exactly READ_LAT+1 edges after the first edge sampling CE=0/OE=0 with stable ADDR.
- Preload:
  - init_we=1 writes init_data to mem[init_addr], full word, one cycle.
  - Accepted in any state.
  - Same-cycle collision with a WR_HOLD commit to the same address -> CPU commit wins.
- Out-of-range: ADDR[19:DEPTH_W]!=0 sets oob and aliases to the low bits.
- conflict and oob clear only on reset.
- Memory is an inferred single-write-port RAM; the write port is shared by preload and commit (commit has priority, preload dropped that cycle).

Decomposition:
- Shared package sram_pkg: state enum sram_state_t {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD}, lane-mask function, default READ_LAT constant.
- One sub-module: sram_array (DEPTH_W-parameterized RAM, one write port with 2-bit byte enable, one async read port).
- FSM, latency counter and flags stay in sram_responder.

Test Plan:
- Preload mem[0x005]=0x1234 via init_we; CE=0, OE=0, WE=1, UB=LB=0, ADDR=0x00005 held -> Data_oe=1 and Data_out=0x1234 exactly 3 edges after strobe (READ_LAT=2).
- Write 0xBEEF to 0x00A with UB=1, LB=0 over mem 0x0000, 2 cycles WE=0 then WE=1 -> readback 0x00EF; repeat with UB=0, LB=1 and data 0xCAFE -> 0xCAEF.
- Read in progress, ADDR changes 0x005->0x006 after 1 cycle -> Data_oe stays 0; valid 0x006 contents appear READ_LAT+1 edges after the change.
- OE=0 and WE=0 together, data 0x5555 to 0x003 -> Data_oe never 1, conflict=1, mem[3]=0x5555 after WE=1.
- ADDR=0x00405 with DEPTH_W=10 -> oob=1, read returns mem[0x005].
- Reset=0 during RD_DRIVE and during WR_HOLD -> Data_oe=0 next cycle, pending write not committed, flags cleared, preloaded data intact.
